// File: rtl/gpio_uart_tx.sv
// rtl/gpio_uart_tx.sv - GPIO-strobed character FIFO feeding a UART 8N1 transmitter
//
// gpio_uart_tx_fifo : small synchronous FIFO holding the characters queued behind the shifter
//   clk, reset     : clock, synchronous active-high reset (flushes pointers and count)
//   push, push_data: write one entry (caller guarantees not full)
//   pop            : drop the head entry (caller guarantees not empty)
//   head           : current head entry, valid while count > 0
//   count          : occupancy, 0 .. 2**AW
//
// gpio_uart_tx : peripheral behind the CPU GPIO pair
//   clk           : system clock shared with the core
//   reset         : synchronous active-high reset; aborts any frame and flushes the FIFO
//   gpio_from_cpu : [7] toggle strobe, [6:0] ASCII character
//   gpio_to_cpu   : [7] ack_toggle, [6] fifo_full, [5] tx_busy, [4:3] 0, [2:0] fifo_count
//   tx_o          : registered UART serial output, idle high

module gpio_uart_tx_fifo #(
   parameter int W  = 8,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [AW:0]   count
);
   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign head = mem[rd_ptr];

   // Storage has no reset: only entries covered by count are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally at DEPTH because they are exactly AW bits wide.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module gpio_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_AW      = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] gpio_from_cpu,
   output logic [7:0] gpio_to_cpu,
   output logic       tx_o
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]    BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [BW-1:0]     baud_cnt;
   logic [BW-1:0]     baud_cnt_n;
   logic [2:0]        bit_idx;
   logic [2:0]        bit_idx_n;
   logic [7:0]        shift;
   logic [7:0]        shift_n;
   logic              tx_n;

   logic [7:0]        cpu_q;
   logic              ack_toggle;
   logic              strobe_pending;
   logic              fifo_full;
   logic              push;
   logic              pop;
   logic [7:0]        fifo_head;
   logic [FIFO_AW:0]  fifo_count;
   logic              baud_last;

   // The core lives on the same clock, so one register stage is enough.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_q      <= 8'h00;
         ack_toggle <= 1'b0;
      end else begin
         cpu_q <= gpio_from_cpu;
         if (push) begin
            ack_toggle <= cpu_q[7];
         end
      end
   end

   // Full is judged on the start-of-cycle count, so a pop never makes room
   // for a push in the same cycle; the strobe simply stays pending.
   assign strobe_pending = (cpu_q[7] != ack_toggle);
   assign fifo_full      = (fifo_count == COUNT_FULL);
   assign push           = strobe_pending && !fifo_full;
   assign pop            = (state == IDLE) && (fifo_count != '0);
   assign baud_last      = (baud_cnt == BAUD_LAST);

   gpio_uart_tx_fifo #(
      .W  (8),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({1'b0, cpu_q[6:0]}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         shift    <= 8'h00;
         tx_o     <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_idx  <= bit_idx_n;
         shift    <= shift_n;
         tx_o     <= tx_n;
      end
   end

   always_comb begin
      state_n    = state;
      baud_cnt_n = baud_cnt;
      bit_idx_n  = bit_idx;
      shift_n    = shift;
      case (state)
         IDLE: begin
            if (pop) begin
               shift_n    = fifo_head;
               bit_idx_n  = 3'd0;
               baud_cnt_n = '0;
               state_n    = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_cnt_n = '0;
               state_n    = DATA;
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_cnt_n = '0;
               shift_n    = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  bit_idx_n = 3'd0;
                  state_n   = STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (baud_last) begin
               baud_cnt_n = '0;
               state_n    = IDLE;
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Line level is computed from the next state so the registered tx_o
   // lines up exactly with the state it belongs to.
   always_comb begin
      tx_n = 1'b1;
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
         default: tx_n = 1'b1;
      endcase
   end

   assign gpio_to_cpu = {ack_toggle, fifo_full, (state != IDLE), 2'b00, 3'(fifo_count)};
endmodule

// File: tb/tb_gpio_uart_tx.sv
// tb/tb_gpio_uart_tx.sv - directed self-checking bench for gpio_uart_tx
module tb_gpio_uart_tx;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] gpio_from_cpu = 8'h00;
   logic [7:0] gpio_to_cpu;
   logic       tx_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rst_cnt = 0;
   logic cur_tog = 1'b0;
   logic [7:0] rx_q [$];
   int         st_q [$];

   gpio_uart_tx #(
      .CLKS_PER_BIT (4),
      .FIFO_AW      (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .gpio_from_cpu (gpio_from_cpu),
      .gpio_to_cpu   (gpio_to_cpu),
      .tx_o          (tx_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) rst_cnt <= rst_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rx_at(input int i);
      if (i < rx_q.size()) return {24'h0, rx_q[i]};
      return 32'h1FF;
   endfunction

   // UART receiver: samples mid-bit, drops frames that overlap a reset.
   initial begin
      int t0;
      int snap;
      logic sb;
      logic sp;
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (!reset && tx_o === 1'b0) begin
            t0   = cyc;
            snap = rst_cnt;
            repeat (2) @(negedge clk);
            sb = tx_o;
            for (int i = 0; i < 8; i++) begin
               repeat (4) @(negedge clk);
               b[i] = tx_o;
            end
            repeat (4) @(negedge clk);
            sp = tx_o;
            if (rst_cnt == snap) begin
               check("start_bit", {31'b0, sb}, 32'd0);
               check("stop_bit", {31'b0, sp}, 32'd1);
               rx_q.push_back(b);
               st_q.push_back(t0);
            end
         end
      end
   end

   task automatic wait_ack();
      logic ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (gpio_to_cpu[7] == cur_tog) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input logic [6:0] ch);
      cur_tog = ~cur_tog;
      gpio_from_cpu = {cur_tog, ch};
      wait_ack();
   endtask

   task automatic wait_idle(input int limit);
      logic ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (!gpio_to_cpu[5] && gpio_to_cpu[2:0] == 3'd0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("idle_timeout", 32'd0, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n;
      // 1. reset
      reset = 1'b1;
      gpio_from_cpu = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_gpio", {24'h0, gpio_to_cpu}, 32'h00);
         check("rst_tx", {31'b0, tx_o}, 32'd1);
      end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("post_rst_gpio", {24'h0, gpio_to_cpu}, 32'h00);
      check("post_rst_tx", {31'b0, tx_o}, 32'd1);

      // 2. single char 'A'
      rx_q.delete(); st_q.delete();
      cur_tog = 1'b1;
      gpio_from_cpu = 8'hC1;
      @(negedge clk);
      check("ack_edge1", {24'h0, gpio_to_cpu}, 32'h00);
      @(negedge clk);
      check("ack_edge2", {24'h0, gpio_to_cpu}, 32'h81);
      @(negedge clk);
      check("pop_busy", {24'h0, gpio_to_cpu}, 32'hA0);
      check("start_low", {31'b0, tx_o}, 32'd0);
      n = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (gpio_to_cpu[5]) n++;
         else break;
      end
      check("busy_cycles", n, 32'd40);
      check("after_frame", {24'h0, gpio_to_cpu}, 32'h80);
      repeat (3) @(negedge clk);
      check("single_count", rx_q.size(), 32'd1);
      check("single_byte", rx_at(0), 32'h41);

      // 3. overflow
      rx_q.delete(); st_q.delete();
      for (int i = 0; i < 5; i++) send(7'h31 + 7'(i));
      check("full_flag", {31'b0, gpio_to_cpu[6]}, 32'd1);
      check("full_count", {29'b0, gpio_to_cpu[2:0]}, 32'd4);
      cur_tog = ~cur_tog;
      gpio_from_cpu = {cur_tog, 7'h36};
      repeat (10) @(negedge clk);
      check("no_ack_full", {31'b0, gpio_to_cpu[7]}, {31'b0, ~cur_tog});
      check("still_full", {29'b0, gpio_to_cpu[2:0]}, 32'd4);
      wait_ack();
      check("refill_count", {29'b0, gpio_to_cpu[2:0]}, 32'd4);
      wait_idle(600);
      check("ovf_count", rx_q.size(), 32'd6);
      for (int i = 0; i < 6; i++) check("ovf_byte", rx_at(i), 32'h31 + i);

      // 4. hold
      rx_q.delete(); st_q.delete();
      send(7'h41);
      repeat (200) @(negedge clk);
      check("hold_count", rx_q.size(), 32'd1);
      check("hold_byte", rx_at(0), 32'h41);
      check("hold_gpio", {24'h0, gpio_to_cpu}, {24'h0, cur_tog, 7'h00});

      // 5. back-to-back
      rx_q.delete(); st_q.delete();
      send(7'h55);
      send(7'h2A);
      wait_idle(300);
      check("b2b_count", rx_q.size(), 32'd2);
      check("b2b_byte0", rx_at(0), 32'h55);
      check("b2b_byte1", rx_at(1), 32'h2A);
      if (st_q.size() == 2) check("b2b_gap", st_q[1] - st_q[0], 32'd41);
      else check("b2b_starts", st_q.size(), 32'd2);

      // 6. reset mid-frame
      rx_q.delete(); st_q.delete();
      send(7'h41);
      send(7'h42);
      send(7'h43);
      repeat (6) @(negedge clk);
      check("mid_busy", {31'b0, gpio_to_cpu[5]}, 32'd1);
      check("mid_count", {29'b0, gpio_to_cpu[2:0]}, 32'd2);
      gpio_from_cpu = 8'h00;
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_tx", {31'b0, tx_o}, 32'd1);
      check("mid_rst_gpio", {24'h0, gpio_to_cpu}, 32'h00);
      @(negedge clk);
      reset = 1'b0;
      cur_tog = 1'b0;
      repeat (200) @(negedge clk);
      check("no_residual", rx_q.size(), 32'd0);
      check("final_gpio", {24'h0, gpio_to_cpu}, 32'h00);
      check("final_tx", {31'b0, tx_o}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
